// File: rtl/sa_pkg.sv
// sa_pkg: shared constants and types for the systolic-array result path.
//   SIZE      : rows and columns per matrix
//   Y_WIDTH   : element width of the result matrix
//   ROW_IDX_W : width of a row index (at least 1 bit)
//   row_t     : one result row, indexed [col]
//   occ_e     : occupancy of the two-slot drain buffer
package sa_pkg;

  localparam int SIZE      = 4;
  localparam int Y_WIDTH   = 16;
  localparam int ROW_IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef logic [SIZE-1:0][Y_WIDTH-1:0] row_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Index width for an arbitrary array dimension (never zero bits).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sa_drain.sv
// sa_drain: converts whole result matrices from the systolic array into a
// row-per-handshake stream. Two matrices can be buffered (ping-pong); a
// third arriving while both slots are occupied is dropped and flagged.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : synchronous active-low reset
//   i_matrix_vld : one-cycle strobe, i_matrix holds a complete matrix
//   i_matrix     : result matrix, indexed [row][col]
//   o_row_vld    : o_row holds a valid row
//   i_row_rdy    : consumer accepts the row when high with o_row_vld
//   o_row        : current row, indexed [col]; zero when not valid
//   o_row_idx    : row number of o_row
//   o_row_last   : o_row is the final row of its matrix
//   o_busy       : at least one matrix is buffered
//   o_ovf        : sticky, a matrix was dropped
//   i_ovf_clr    : clears o_ovf
import sa_pkg::*;

module sa_drain #(
  parameter int SIZE    = sa_pkg::SIZE,
  parameter int Y_WIDTH = sa_pkg::Y_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      i_matrix_vld,
  input  logic [SIZE-1:0][SIZE-1:0][Y_WIDTH-1:0]    i_matrix,
  output logic                                      o_row_vld,
  input  logic                                      i_row_rdy,
  output logic [SIZE-1:0][Y_WIDTH-1:0]              o_row,
  output logic [sa_pkg::idx_width(SIZE)-1:0]        o_row_idx,
  output logic                                      o_row_last,
  output logic                                      o_busy,
  output logic                                      o_ovf,
  input  logic                                      i_ovf_clr
);

  localparam int IDX_W = sa_pkg::idx_width(SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  typedef logic [SIZE-1:0][Y_WIDTH-1:0] lrow_t;
  typedef lrow_t [SIZE-1:0]             lmat_t;

  // Ping-pong storage; contents are only observed through a valid slot,
  // so it carries no reset.
  lmat_t            slot_r [2];

  occ_e             state_r;
  occ_e             state_nxt_s;
  logic             wr_ptr_r;
  logic             wr_ptr_nxt_s;
  logic             rd_ptr_r;
  logic             rd_ptr_nxt_s;
  logic [IDX_W-1:0] row_cnt_r;
  logic [IDX_W-1:0] row_cnt_nxt_s;

  logic             pop_s;
  logic             last_pop_s;
  logic             wr_en_s;
  logic             ovf_set_s;

  logic             row_vld_r;
  logic             row_vld_nxt_s;
  lrow_t            row_r;
  lrow_t            row_nxt_s;
  logic [IDX_W-1:0] row_idx_r;
  logic             row_last_r;
  logic             row_last_nxt_s;
  logic             busy_r;
  logic             ovf_r;
  logic             ovf_nxt_s;

  // Handshake decode: a pop of the final row frees a slot in the same cycle,
  // which lets a capture in FULL be accepted instead of dropped.
  always_comb begin
    pop_s      = (state_r != OCC_EMPTY) && i_row_rdy;
    last_pop_s = pop_s && (row_cnt_r == LAST_IDX);
    wr_en_s    = i_matrix_vld && ((state_r != OCC_FULL) || last_pop_s);
    ovf_set_s  = i_matrix_vld && (state_r == OCC_FULL) && !last_pop_s;
  end

  // Occupancy FSM next state plus pointer/row-counter next values.
  always_comb begin
    state_nxt_s   = state_r;
    wr_ptr_nxt_s  = wr_ptr_r;
    rd_ptr_nxt_s  = rd_ptr_r;
    row_cnt_nxt_s = row_cnt_r;

    case (state_r)
      OCC_EMPTY: begin
        if (wr_en_s) begin
          state_nxt_s = OCC_ONE;
        end else begin
          state_nxt_s = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (wr_en_s && !last_pop_s) begin
          state_nxt_s = OCC_FULL;
        end else if (!wr_en_s && last_pop_s) begin
          state_nxt_s = OCC_EMPTY;
        end else begin
          state_nxt_s = OCC_ONE;
        end
      end
      OCC_FULL: begin
        if (last_pop_s && !wr_en_s) begin
          state_nxt_s = OCC_ONE;
        end else begin
          state_nxt_s = OCC_FULL;
        end
      end
      default: begin
        state_nxt_s = OCC_EMPTY;
      end
    endcase

    if (wr_en_s) begin
      wr_ptr_nxt_s = ~wr_ptr_r;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (last_pop_s) begin
      rd_ptr_nxt_s  = ~rd_ptr_r;
      row_cnt_nxt_s = '0;
    end else if (pop_s) begin
      rd_ptr_nxt_s  = rd_ptr_r;
      row_cnt_nxt_s = row_cnt_r + IDX_W'(1);
    end else begin
      rd_ptr_nxt_s  = rd_ptr_r;
      row_cnt_nxt_s = row_cnt_r;
    end
  end

  // Next output row. The slot being written this cycle can only be the one
  // the read side lands on when it holds no older data (buffer empty, or the
  // last row of the only matrix is popping), so bypass i_matrix in that case.
  always_comb begin
    row_vld_nxt_s  = (state_nxt_s != OCC_EMPTY);
    row_nxt_s      = '0;
    row_last_nxt_s = row_vld_nxt_s && (row_cnt_nxt_s == LAST_IDX);

    if (!row_vld_nxt_s) begin
      row_nxt_s = '0;
    end else if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      row_nxt_s = i_matrix[row_cnt_nxt_s];
    end else begin
      row_nxt_s = slot_r[rd_ptr_nxt_s][row_cnt_nxt_s];
    end
  end

  // Sticky overflow: a same-cycle drop wins over a clear.
  always_comb begin
    if (ovf_set_s) begin
      ovf_nxt_s = 1'b1;
    end else if (i_ovf_clr) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // Occupancy FSM state register and pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= OCC_EMPTY;
      wr_ptr_r  <= 1'b0;
      rd_ptr_r  <= 1'b0;
      row_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      wr_ptr_r  <= wr_ptr_nxt_s;
      rd_ptr_r  <= rd_ptr_nxt_s;
      row_cnt_r <= row_cnt_nxt_s;
    end
  end

  // Matrix capture into the slot selected by the write pointer.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_s) begin
      slot_r[wr_ptr_r] <= i_matrix;
    end
  end

  // Registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_vld_r  <= 1'b0;
      row_r      <= '0;
      row_idx_r  <= '0;
      row_last_r <= 1'b0;
      busy_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      row_vld_r  <= row_vld_nxt_s;
      row_r      <= row_nxt_s;
      row_idx_r  <= row_vld_nxt_s ? row_cnt_nxt_s : '0;
      row_last_r <= row_last_nxt_s;
      busy_r     <= row_vld_nxt_s;
      ovf_r      <= ovf_nxt_s;
    end
  end

  assign o_row_vld  = row_vld_r;
  assign o_row      = row_r;
  assign o_row_idx  = row_idx_r;
  assign o_row_last = row_last_r;
  assign o_busy     = busy_r;
  assign o_ovf      = ovf_r;

endmodule
